// File: rtl/clk_rate_controller_pkg.sv
// Shared definitions for the clock rate controller: FSM state encoding,
// the default level-0 half period and a counter-width helper.
package clk_rate_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSE   = 2'd1,
        ST_STEP_HI = 2'd2,
        ST_STEP_LO = 2'd3
    } state_t;

    // 1 Hz divided clock from a 100 MHz system clock
    localparam int DEFAULT_BASE_HALF = 49_999_999;

    // Bits needed to count 0 .. n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_rate_controller_btn_debouncer.sv
// Button debouncer: two-flop synchroniser, stable-sample counter and a
// one-cycle pulse on the debounced rising edge. Holding the button never
// repeats the pulse.
module btn_debouncer
    import clk_rate_controller_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int DEB_W = cnt_width(DEB_CYCLES);

    logic             sync_1;
    logic             sync_2;
    logic             deb;
    logic             deb_q;
    logic [DEB_W-1:0] stable_cnt;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            deb        <= 1'b0;
            deb_q      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            deb_q <= deb;
            if (sync_2 == deb) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                deb        <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + DEB_W'(1);
            end
        end
    end

    assign press = deb & ~deb_q;

endmodule

// File: rtl/clk_rate_controller.sv
// Clock rate controller: divides clk into clk_n at one of NUM_LEVELS rates
// (each level doubles the rate), with RUN/PAUSE mode and single-step of one
// full clk_n period. tick marks the clk cycle in which clk_n rises.
//
//  state      | meaning
//  -----------+--------------------------------------------------------
//  ST_RUN     | free-running divider
//  ST_PAUSE   | counter frozen, clk_n held low (a high phase finishes)
//  ST_STEP_HI | single step, high half of the period
//  ST_STEP_LO | single step, low half of the period
module clk_rate_controller
    import clk_rate_controller_pkg::*;
#(
    parameter int NUM_LEVELS = 6,
    parameter int BASE_HALF  = DEFAULT_BASE_HALF,
    parameter int CNT_W      = 32,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int LVL_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_faster,
    input  logic             btn_slower,
    input  logic             btn_pause,
    input  logic             btn_step,
    output logic             clk_n,
    output logic             tick,
    output logic [LVL_W-1:0] curr_level,
    output logic             paused
);

    localparam logic [LVL_W-1:0] TOP_LEVEL = LVL_W'(NUM_LEVELS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clk_nxt;
    logic [CNT_W-1:0] half_cur;
    logic             term;
    logic             ev_faster;
    logic             ev_slower;
    logic             ev_pause;
    logic             ev_step;
    logic             lvl_up;
    logic             lvl_dn;
    logic             lvl_chg;
    logic             step_start;

    btn_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_faster (
        .clk(clk), .rst(rst), .raw(btn_faster), .press(ev_faster)
    );
    btn_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_slower (
        .clk(clk), .rst(rst), .raw(btn_slower), .press(ev_slower)
    );
    btn_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk(clk), .rst(rst), .raw(btn_pause), .press(ev_pause)
    );
    btn_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .rst(rst), .raw(btn_step), .press(ev_step)
    );

    // Half period for the current level; the fastest level toggles every cycle
    always_comb begin
        if (curr_level == TOP_LEVEL) begin
            half_cur = '0;
        end else begin
            half_cur = CNT_W'(BASE_HALF) >> curr_level;
        end
    end

    assign term       = (counter >= half_cur);
    assign lvl_up     = ev_faster & ~ev_slower & (curr_level != TOP_LEVEL);
    assign lvl_dn     = ev_slower & ~ev_faster & (curr_level != '0);
    assign lvl_chg    = lvl_up | lvl_dn;
    assign step_start = (state == ST_PAUSE) & ~ev_pause & ev_step & ~clk_n;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; a level change restarts the count so a step phase
    // cannot end in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (ev_pause) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (ev_pause)        state_nxt = ST_RUN;
                else if (step_start) state_nxt = ST_STEP_HI;
            end
            ST_STEP_HI: begin
                if (term && !lvl_chg) state_nxt = ST_STEP_LO;
            end
            ST_STEP_LO: begin
                if (term && !lvl_chg) state_nxt = ST_PAUSE;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        paused = (state != ST_RUN);
    end

    // Divider next values; a level change clears the counter and cancels any
    // toggle, but the rising edge of a new step still goes out
    always_comb begin
        cnt_nxt = counter;
        clk_nxt = clk_n;
        case (state)
            ST_RUN: begin
                if (term) begin
                    cnt_nxt = '0;
                    clk_nxt = ~clk_n;
                end else begin
                    cnt_nxt = counter + CNT_W'(1);
                end
            end
            ST_PAUSE: begin
                if (ev_pause) begin
                    cnt_nxt = '0;
                end else if (step_start) begin
                    cnt_nxt = '0;
                    clk_nxt = 1'b1;
                end else if (clk_n) begin
                    if (term) begin
                        cnt_nxt = '0;
                        clk_nxt = 1'b0;
                    end else begin
                        cnt_nxt = counter + CNT_W'(1);
                    end
                end
            end
            ST_STEP_HI: begin
                if (term) begin
                    cnt_nxt = '0;
                    clk_nxt = 1'b0;
                end else begin
                    cnt_nxt = counter + CNT_W'(1);
                end
            end
            ST_STEP_LO: begin
                if (term) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = counter + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
            end
        endcase
        if (lvl_chg) begin
            cnt_nxt = '0;
            if (!step_start) clk_nxt = clk_n;
        end
    end

    // Divider, tick and level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            counter    <= '0;
            clk_n      <= 1'b0;
            tick       <= 1'b0;
            curr_level <= '0;
        end else begin
            counter <= cnt_nxt;
            clk_n   <= clk_nxt;
            tick    <= clk_nxt & ~clk_n;
            if (lvl_up) begin
                curr_level <= curr_level + LVL_W'(1);
            end else if (lvl_dn) begin
                curr_level <= curr_level - LVL_W'(1);
            end
        end
    end

endmodule
